// File: rtl/lif_layer.sv
// One fully-connected layer of leaky integrate-and-fire neurons with 1-bit signed synapses,
// per-neuron batch-norm scale/offset, shared leak shift and threshold, reset-by-subtraction.
module lif_layer #(
  parameter int IN_BITS = 5,
  parameter int NEURONS = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ce,
  input  logic [2**IN_BITS-1:0]             x,
  input  logic [2**IN_BITS*NEURONS-1:0]     w,
  input  logic [2**IN_BITS*NEURONS-1:0]     connection_enabled,
  input  logic [2:0]                        beta_shift,
  input  logic [IN_BITS+1:0]                minus_teta,
  input  logic [4*NEURONS-1:0]              BN_factor,
  input  logic [(IN_BITS+2)*NEURONS-1:0]    BN_addend,
  output logic [NEURONS-1:0]                spike_out
);

  localparam int I   = 2**IN_BITS;
  localparam int S_W = IN_BITS + 2;   // synapse sum, -I..+I
  localparam int B_W = IN_BITS + 6;   // batch-norm result, exact
  localparam int U_W = IN_BITS + 8;   // membrane potential

  localparam logic signed [U_W-1:0] U_MAX = {1'b0, {(U_W-1){1'b1}}};
  localparam logic signed [U_W-1:0] U_MIN = {1'b1, {(U_W-1){1'b0}}};

  // Clamp a one-bit-wider sum back into the membrane range instead of wrapping.
  function automatic logic signed [U_W-1:0] sat(input logic signed [U_W:0] v);
    if (v[U_W] != v[U_W-1]) return v[U_W] ? U_MIN : U_MAX;
    return v[U_W-1:0];
  endfunction

  logic [NEURONS-1:0] fire_vec;

  for (genvar j = 0; j < NEURONS; j++) begin : g_neuron
    logic signed [S_W-1:0] s;
    logic signed [B_W-1:0] s_ext, f_ext, a_ext, b;
    logic signed [U_W-1:0] u_q, d, p, u_d;
    logic signed [U_W:0]   sum_p, sum_t;
    logic                  fire;

    // NOTE: the default assignment before the loop keeps this combinational; without it a
    // path that never writes s would infer a latch.
    always_comb begin
      s = '0;
      for (int i = 0; i < I; i++) begin
        if (x[i] && connection_enabled[i*NEURONS+j])
          s = w[i*NEURONS+j] ? s + S_W'(1) : s - S_W'(1);
      end
    end

    assign s_ext = B_W'(s);
    assign f_ext = B_W'($signed(BN_factor[4*j +: 4]));
    assign a_ext = B_W'($signed(BN_addend[S_W*j +: S_W]));
    assign b     = s_ext * f_ext + a_ext;

    // Leak keeps u - (u >>> k); k = 0 discards the whole potential.
    assign d     = u_q - (u_q >>> beta_shift);
    assign sum_p = (U_W+1)'(d) + (U_W+1)'(b);
    assign p     = sat(sum_p);

    assign sum_t = (U_W+1)'(p) + (U_W+1)'($signed(minus_teta));
    assign fire  = ~sum_t[U_W];
    assign u_d   = fire ? sat(sum_t) : p;

    // NOTE: state registers use non-blocking assignments so every neuron samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
      if (!rst_n)  u_q <= '0;
      else if (ce) u_q <= u_d;
    end

    assign fire_vec[j] = fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  spike_out <= '0;
    else if (ce) spike_out <= fire_vec;
  end

endmodule

// File: tb/tb_lif_layer.sv
// Self-checking bench for lif_layer (IN_BITS=2, NEURONS=2): directed scenarios plus random
// stimulus, all compared against an integer reference model of the neuron equations.
module tb_lif_layer;

  localparam int IN_BITS = 2;
  localparam int NEURONS = 2;
  localparam int I       = 4;
  localparam int U_MAX   = 511;
  localparam int U_MIN   = -512;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           ce;
  logic [I-1:0]                   x;
  logic [I*NEURONS-1:0]           w;
  logic [I*NEURONS-1:0]           conn;
  logic [2:0]                     beta_shift;
  logic [IN_BITS+1:0]             minus_teta;
  logic [4*NEURONS-1:0]           bn_factor;
  logic [(IN_BITS+2)*NEURONS-1:0] bn_addend;
  logic [NEURONS-1:0]             spike_out;

  int n_tests = 0;
  int n_fail  = 0;

  int                 mu[NEURONS];
  logic [NEURONS-1:0] exp_spk;

  lif_layer #(.IN_BITS(IN_BITS), .NEURONS(NEURONS)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ce                 (ce),
    .x                  (x),
    .w                  (w),
    .connection_enabled (conn),
    .beta_shift         (beta_shift),
    .minus_teta         (minus_teta),
    .BN_factor          (bn_factor),
    .BN_addend          (bn_addend),
    .spike_out          (spike_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > U_MAX) return U_MAX;
    if (v < U_MIN) return U_MIN;
    return v;
  endfunction

  // Reference: what the next rising edge should do, from the current inputs and model state.
  task automatic model_edge();
    int s, f, a, b, d, p, t;
    if (!rst_n) begin
      foreach (mu[j]) mu[j] = 0;
      exp_spk = '0;
    end else if (ce) begin
      for (int j = 0; j < NEURONS; j++) begin
        s = 0;
        for (int i = 0; i < I; i++)
          if (x[i] && conn[i*NEURONS+j]) s += w[i*NEURONS+j] ? 1 : -1;
        f = $signed(bn_factor[4*j +: 4]);
        a = $signed(bn_addend[4*j +: 4]);
        b = s * f + a;
        d = mu[j] - (mu[j] >>> beta_shift);
        p = clamp(d + b);
        t = p + $signed(minus_teta);
        exp_spk[j] = (t >= 0);
        mu[j]      = (t >= 0) ? clamp(t) : p;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check(tag, 32'(spike_out), 32'(exp_spk));
  endtask

  task automatic cfg(input logic [3:0] cx, input logic [7:0] cw, input logic [7:0] cc,
                     input logic [2:0] cb, input logic [3:0] cmt,
                     input logic [3:0] cf, input logic [3:0] ca);
    x = cx; w = cw; conn = cc; beta_shift = cb; minus_teta = cmt;
    bn_factor = {cf, cf};
    bn_addend = {ca, ca};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ce    = 1'b1;
    tick("reset");
    rst_n = 1'b1;
  endtask

  logic [1:0] seq1[4] = '{2'b00, 2'b11, 2'b11, 2'b00};
  logic [1:0] seq3[4] = '{2'b00, 2'b11, 2'b00, 2'b11};

  initial begin
    rst_n = 1'b0; ce = 1'b0;
    cfg(4'h0, 8'h00, 8'h00, 3'd0, 4'h0, 4'h1, 4'h0);
    #2;
    do_reset();

    // Integrate +4 per step against threshold 6 (minus_teta = -6 = 4'hA).
    cfg(4'hF, 8'hFF, 8'hFF, 3'd7, 4'hA, 4'h1, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick("s1_model");
      check("s1_seq", 32'(spike_out), 32'(seq1[k]));
    end

    // All-inhibitory input with half leak settles at -7 and never fires.
    do_reset();
    cfg(4'hF, 8'h00, 8'hFF, 3'd1, 4'hA, 4'h1, 4'h0);
    for (int k = 0; k < 6; k++) begin
      tick("s2_model");
      check("s2_quiet", 32'(spike_out), 32'h0);
    end

    // No synapses, bias-only drive from the addend.
    do_reset();
    cfg(4'hF, 8'hFF, 8'h00, 3'd7, 4'hA, 4'h0, 4'h3);
    for (int k = 0; k < 4; k++) begin
      tick("s3_model");
      check("s3_seq", 32'(spike_out), 32'(seq3[k]));
    end

    // Neuron 0 sees only input 0 (s=+1), neuron 1 sees all four (s=+4).
    do_reset();
    cfg(4'hF, 8'hFF, 8'hAB, 3'd7, 4'hA, 4'h1, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      tick("s4_model");
      if (k == 2) check("s4_only_n1", 32'(spike_out), 32'h2);
      if (k == 6) check("s4_both", 32'(spike_out), 32'h3);
    end

    // Hold with ce low while inputs toggle, then resume the sequence.
    do_reset();
    cfg(4'hF, 8'hFF, 8'hFF, 3'd7, 4'hA, 4'h1, 4'h0);
    tick("s5_run");
    tick("s5_run");
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x = 4'(k * 5);
      w = 8'($urandom);
      tick("s5_hold_model");
      check("s5_hold", 32'(spike_out), 32'h3);
    end
    cfg(4'hF, 8'hFF, 8'hFF, 3'd7, 4'hA, 4'h1, 4'h0);
    ce = 1'b1;
    tick("s5_resume_model");
    check("s5_resume3", 32'(spike_out), 32'h3);
    tick("s5_resume_model");
    check("s5_resume4", 32'(spike_out), 32'h0);

    // Reset mid-run overrides ce, then the sequence restarts from the beginning.
    tick("s6_run");
    tick("s6_run");
    rst_n = 1'b0;
    tick("s6_reset_model");
    check("s6_reset", 32'(spike_out), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick("s6_model");
      check("s6_seq", 32'(spike_out), 32'(seq1[k]));
    end

    // Strong drive: potential clamps at +511 and must keep firing every step.
    do_reset();
    cfg(4'hF, 8'hFF, 8'hFF, 3'd7, 4'h7, 4'h7, 4'h7);
    for (int k = 0; k < 40; k++) begin
      tick("s7_model");
      check("s7_fire", 32'(spike_out), 32'h3);
    end
    // Drain the clamped potential through the leak to expose its value.
    cfg(4'h0, 8'h00, 8'h00, 3'd1, 4'h8, 4'h0, 4'h0);
    for (int k = 0; k < 12; k++) tick("s7_drain");

    // Random traffic: all inputs change freely, ce and reset asserted at random.
    for (int k = 0; k < 600; k++) begin
      x          = 4'($urandom);
      w          = 8'($urandom);
      conn       = 8'($urandom);
      beta_shift = 3'($urandom);
      minus_teta = 4'($urandom);
      bn_factor  = 8'($urandom);
      bn_addend  = 8'($urandom);
      ce         = ($urandom_range(0, 3) != 0);
      rst_n      = ($urandom_range(0, 49) != 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
